// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ frame-based requesters.
// Optional stall timeout: define UART_ARB_TIMEOUT_EN to revoke a grant after TIMEOUT_CYCLES idle cycles.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    input  logic [8*NUM_REQ-1:0]   i_req_data,
    input  logic [NUM_REQ-1:0]     i_req_last,
    output logic [NUM_REQ-1:0]     o_req_ready,
    output logic                   o_tx_valid,
    output logic [7:0]             o_tx_data,
    input  logic                   i_tx_ready,
    output logic [NUM_REQ-1:0]     o_grant,
    output logic                   o_busy,
    output logic                   o_timeout_abort
);
    // state  | meaning
    // IDLE   | no owner; pick next requester at or above r_ptr (wrapping)
    // STREAM | r_owner's lane is passed straight through to the transmitter
    typedef enum logic {S_IDLE, S_STREAM} state_t;

    localparam int PW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("uart_tx_arbiter: parameter out of range");
    end

    state_t               r_state;
    logic [PW-1:0]        r_ptr;
    logic [PW-1:0]        r_owner;
    logic [NUM_REQ-1:0]   r_grant;

    logic [7:0]           w_lane [NUM_REQ];
    logic [2*NUM_REQ-1:0] w_rot;
    logic                 w_sel_found;
    logic [PW-1:0]        w_sel_off;
    logic [PW:0]          w_sel_sum;
    logic [PW-1:0]        w_sel_idx;
    logic                 w_streaming;
    logic                 w_own_valid;
    logic                 w_own_last;
    logic                 w_hs;
    logic [PW-1:0]        w_next_ptr;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        assign w_lane[gi] = i_req_data[8*gi +: 8];
    end

    // Rotating the request vector by r_ptr turns wrap-around search into a plain priority pick.
    assign w_rot = {i_req_valid, i_req_valid} >> r_ptr;

    always_comb begin
        w_sel_found = 1'b0;
        w_sel_off   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_sel_found && w_rot[k]) begin
                w_sel_found = 1'b1;
                w_sel_off   = PW'(k);
            end
        end
    end

    assign w_sel_sum = {1'b0, r_ptr} + {1'b0, w_sel_off};
    assign w_sel_idx = (w_sel_sum >= (PW+1)'(NUM_REQ)) ? PW'(w_sel_sum - (PW+1)'(NUM_REQ))
                                                       : w_sel_sum[PW-1:0];

    assign w_streaming = (r_state == S_STREAM);
    assign w_own_valid = i_req_valid[r_owner];
    assign w_own_last  = i_req_last[r_owner];
    assign w_hs        = w_streaming && w_own_valid && i_tx_ready;
    assign w_next_ptr  = (r_owner == PW'(NUM_REQ-1)) ? '0 : r_owner + 1'b1;

    assign o_tx_valid  = w_streaming && w_own_valid;
    assign o_tx_data   = w_streaming ? w_lane[r_owner] : 8'h00;
    assign o_req_ready = (w_streaming && i_tx_ready) ? r_grant : '0;
    assign o_grant     = r_grant;
    assign o_busy      = w_streaming;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int SW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT_CYCLES - 1);

    logic [SW-1:0] r_stall;
    logic          r_abort;

    assign o_timeout_abort = r_abort;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_grant <= '0;
            r_stall <= '0;
            r_abort <= 1'b0;
        end else begin
            r_abort <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_sel_found) begin
                        r_owner <= w_sel_idx;
                        r_grant <= NUM_REQ'(1) << w_sel_idx;
                        r_stall <= '0;
                        r_state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_hs) begin
                        r_stall <= '0;
                        if (w_own_last) begin
                            r_ptr   <= w_next_ptr;
                            r_grant <= '0;
                            r_state <= S_IDLE;
                        end
                    end else if (!w_own_valid) begin
                        // Backpressure (valid high, tx_ready low) never reaches this branch.
                        if (r_stall == STALL_LAST) begin
                            r_abort <= 1'b1;
                            r_ptr   <= w_next_ptr;
                            r_grant <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_stall <= r_stall + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
`else
    assign o_timeout_abort = 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_grant <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_sel_found) begin
                        r_owner <= w_sel_idx;
                        r_grant <= NUM_REQ'(1) << w_sel_idx;
                        r_state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_hs && w_own_last) begin
                        r_ptr   <= w_next_ptr;
                        r_grant <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed frames plus random traffic against a frame-level model.
// The stall-timeout scenario runs only when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;
    localparam int NR = 4;
    localparam int IW = 2;
    localparam int TC = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NR-1:0] req_valid = '0;
    logic [8*NR-1:0] req_data = '0;
    logic [NR-1:0] req_last = '0;
    logic [NR-1:0] req_ready;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready = 1'b1;
    logic [NR-1:0] grant;
    logic          busy;
    logic          timeout_abort;

    uart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TC)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid), .i_req_data(req_data), .i_req_last(req_last),
        .o_req_ready(req_ready), .o_tx_valid(tx_valid), .o_tx_data(tx_data),
        .i_tx_ready(tx_ready), .o_grant(grant), .o_busy(busy),
        .o_timeout_abort(timeout_abort)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: who owns the wire, where the round-robin pointer sits, stall length.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_stall = 0;
    bit m_abort = 0;
    bit m_live  = 0;
    int m_hs_lane = -1;

    always @(posedge clk) begin
        m_hs_lane = -1;
        if (!rst_n) begin
            m_owner = -1; m_ptr = 0; m_stall = 0; m_abort = 0; m_live = 1;
        end else if (m_live) begin
            m_abort = 0;
            if (m_owner < 0) begin
                for (int k = 0; k < NR; k++) begin
                    int idx;
                    idx = (m_ptr + k) % NR;
                    if (m_owner < 0 && req_valid[IW'(idx)]) begin
                        m_owner = idx;
                        m_stall = 0;
                    end
                end
            end else if (req_valid[IW'(m_owner)] && tx_ready) begin
                m_hs_lane = m_owner;
                m_stall = 0;
                if (req_last[IW'(m_owner)]) begin
                    m_ptr = (m_owner + 1) % NR;
                    m_owner = -1;
                end
            end else if (!req_valid[IW'(m_owner)]) begin
`ifdef UART_ARB_TIMEOUT_EN
                m_stall++;
                if (m_stall == TC) begin
                    m_abort = 1;
                    m_ptr = (m_owner + 1) % NR;
                    m_owner = -1;
                end
`endif
            end
        end
    end

    // Single compare process: every output, every cycle, once the model has seen reset.
    always @(negedge clk) begin
        if (m_live) begin
            logic [NR-1:0] e_grant;
            logic          e_txv;
            logic [7:0]    e_txd;
            e_grant = (m_owner >= 0) ? NR'(1) << m_owner : '0;
            e_txv   = (m_owner >= 0) && req_valid[IW'(m_owner)];
            e_txd   = (m_owner >= 0) ? req_data[8*m_owner +: 8] : 8'h00;
            chk("cmp_grant", 32'(grant), 32'(e_grant));
            chk("cmp_busy", 32'(busy), 32'(m_owner >= 0));
            chk("cmp_tx_valid", 32'(tx_valid), 32'(e_txv));
            chk("cmp_tx_data", 32'(tx_data), 32'(e_txd));
            chk("cmp_req_ready", 32'(req_ready), 32'(tx_ready ? e_grant : '0));
            chk("cmp_abort", 32'(timeout_abort), 32'(m_abort));
        end
    end

    // Requester agents: per-lane byte FIFOs, {last, byte}.
    logic [8:0] fifo [NR][64];
    int head [NR];
    int tail [NR];
    bit rnd_mode = 0;

    task automatic push(input int lane, input logic [7:0] b, input bit last);
        fifo[lane][tail[lane] % 64] = {last, b};
        tail[lane]++;
    endtask

    task automatic agent_update();
        for (int i = 0; i < NR; i++) begin
            logic [8:0] e;
            if (m_hs_lane == i) head[i]++;
            if (!(req_valid[IW'(i)] && m_hs_lane != i)) begin
                if (head[i] != tail[i] && (!rnd_mode || $urandom_range(3) != 0)) begin
                    e = fifo[i][head[i] % 64];
                    req_valid[IW'(i)] = 1'b1;
                    req_last[IW'(i)]  = e[8];
                    req_data[8*i +: 8] = e[7:0];
                end else begin
                    req_valid[IW'(i)] = 1'b0;
                    req_last[IW'(i)]  = 1'b0;
                    req_data[8*i +: 8] = rnd_mode ? 8'($urandom) : 8'h00;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        agent_update();
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NR; i++) begin head[i] = 0; tail[i] = 0; end
        req_valid = '0; req_last = '0; req_data = '0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NR; i++) begin head[i] = 0; tail[i] = 0; end

        // Reset state, then requester 1 sends 0x41,0x42,0x43.
        do_reset();
        neg();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        push(1, 8'h41, 0); push(1, 8'h42, 0); push(1, 8'h43, 1);
        tick(); neg();
        chk("t1_req_cycle_grant", 32'(grant), 0);
        tick(); neg();
        chk("t1_b0", 32'(tx_data), 32'h41);
        chk("t1_g0", 32'(grant), 32'h2);
        tick(); neg();
        chk("t1_b1", 32'(tx_data), 32'h42);
        tick(); neg();
        chk("t1_b2", 32'(tx_data), 32'h43);
        chk("t1_g2", 32'(grant), 32'h2);
        tick(); neg();
        chk("t1_end_grant", 32'(grant), 0);
        chk("t1_end_busy", 32'(busy), 0);

        // Requesters 0 and 2 together: frame 0, one idle cycle, then frame 2.
        do_reset();
        push(0, 8'hA0, 0); push(0, 8'hA1, 1);
        push(2, 8'hC0, 0); push(2, 8'hC1, 1);
        begin
            logic [7:0] exp_d [6] = '{8'h00, 8'hA0, 8'hA1, 8'h00, 8'hC0, 8'hC1};
            logic [3:0] exp_g [6] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4};
            for (int c = 0; c < 6; c++) begin
                tick(); neg();
                chk("t2_data", 32'(tx_data), 32'(exp_d[c]));
                chk("t2_grant", 32'(grant), 32'(exp_g[c]));
            end
        end

        // All four send single-byte frames back to back: grant 0,1,2,3,0 every other cycle.
        do_reset();
        for (int i = 0; i < NR; i++) begin
            push(i, 8'(8'h10 + i), 1);
            push(i, 8'(8'h20 + i), 1);
        end
        for (int c = 0; c < 10; c++) begin
            tick(); neg();
            chk("t3_grant", 32'(grant), (c % 2 == 1) ? 32'(1 << ((c / 2) % 4)) : 0);
        end

        // Requester 3 under 100 cycles of backpressure: held, no abort.
        do_reset();
        tx_ready = 1'b0;
        push(3, 8'h77, 1);
        tick();
        for (int c = 0; c < 100; c++) begin
            tick(); neg();
            chk("t4_hold_ready", 32'(req_ready), 0);
            chk("t4_hold_data", 32'(tx_data), 32'h77);
            chk("t4_no_abort", 32'(timeout_abort), 0);
        end
        tick();
        tx_ready = 1'b1;
        neg();
        chk("t4_accept", 32'(req_ready), 32'h8);
        tick(); neg();
        chk("t4_release", 32'(grant), 0);

`ifdef UART_ARB_TIMEOUT_EN
        // Requester 0 stalls mid-frame; requester 1 is waiting.
        do_reset();
        push(0, 8'h55, 0);
        push(1, 8'h66, 1);
        tick();
        for (int c = 1; c <= 19; c++) begin
            tick(); neg();
            if (c == 17) begin
                chk("t5_pre_abort", 32'(timeout_abort), 0);
                chk("t5_pre_grant", 32'(grant), 32'h1);
            end
            if (c == 18) begin
                chk("t5_abort", 32'(timeout_abort), 1);
                chk("t5_abort_grant", 32'(grant), 0);
            end
            if (c == 19) begin
                chk("t5_next_grant", 32'(grant), 32'h2);
                chk("t5_abort_gone", 32'(timeout_abort), 0);
            end
        end
`endif

        // Reset during the second byte of a frame.
        do_reset();
        push(0, 8'h01, 0); push(0, 8'h02, 0); push(0, 8'h03, 1);
        push(3, 8'h99, 1);
        tick(); tick(); tick();
        rst_n = 1'b0;
        neg();
        tick(); neg();
        chk("t6_grant", 32'(grant), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_tx_valid", 32'(tx_valid), 0);
        rst_n = 1'b1;
        tick(); neg();
        chk("t6_prio0", 32'(grant), 32'h1);

        // Random traffic with random backpressure.
        do_reset();
        rnd_mode = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (head[i] == tail[i] && $urandom_range(7) == 0) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) push(i, 8'($urandom), b == len - 1);
                end
            end
            tick();
            tx_ready = ($urandom_range(3) != 0);
        end
        tick(); neg();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
